commit_trace_buffer: RTL and testbench

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_buffer.sv | 143 ++++++++++++++
 tb/tb_commit_trace_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: records WB register commits and MEM stores into a FWFT FIFO, plus event counters.
// Latency: a record pushed at edge N is presented on Rd_* after edge N; counters update at the same edge.
// Backpressure: Rd_Ready pops the head; pushes into a full FIFO without a pop are dropped and counted.
module commit_trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Trace_En,
  input  logic                     WB_RegWrite,
  input  logic [4:0]               WB_WriteRegister,
  input  logic [31:0]              WB_WriteData,
  input  logic [31:0]              WB_PCPlus8,
  input  logic                     MEM_MemWrite,
  input  logic [31:0]              MEM_PCPlus8,
  input  logic                     ID_PCWrite,
  input  logic                     ID_BranchTaken,
  input  logic                     ID_DoJump,
  input  logic                     ID_DoJR,
  input  logic                     Rd_Ready,
  output logic                     Rd_Valid,
  output logic                     Rd_Type,
  output logic [15:0]              Rd_Cycle,
  output logic [31:0]              Rd_PC,
  output logic [4:0]               Rd_Reg,
  output logic [31:0]              Rd_Value,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Overflow,
  output logic [15:0]              DropCount,
  output logic [15:0]              StallCount,
  output logic [15:0]              BranchCount,
  output logic [15:0]              JumpCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic        typ;
    logic [15:0] cyc;
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] val;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             new_rec;
  rec_t             head_rec;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level_q;
  logic [15:0]      cycle_cnt;
  logic             rd_vld;
  logic             pop;
  logic             push_req;
  logic             full;
  logic             push;
  logic             drop;

  // Saturating 16-bit increment; counters stick at 0xFFFF rather than wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // Handshake decode: a full FIFO still accepts a push when the head leaves in the same cycle.
  assign rd_vld   = (level_q != '0);
  assign pop      = rd_vld & Rd_Ready;
  assign push_req = Trace_En & (WB_RegWrite | MEM_MemWrite);
  assign full     = (level_q == FULL_LVL);
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Build the candidate record; a WB commit wins over a simultaneous store.
  always_comb begin
    new_rec     = '0;
    new_rec.cyc = cycle_cnt;
    if (WB_RegWrite) begin
      new_rec.typ = 1'b0;
      new_rec.pc  = WB_PCPlus8 - 32'd8;
      new_rec.rg  = WB_WriteRegister;
      new_rec.val = WB_WriteData;
    end else begin
      new_rec.typ = 1'b1;
      new_rec.pc  = MEM_PCPlus8 - 32'd8;
    end
  end

  // Record storage; contents need no reset because the read side is gated by the occupancy.
  always_ff @(posedge Clk) begin
    if (!Reset && push) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  // Pointer, occupancy and cycle stamp bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 16'd1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overflow flag and event counters; only traced cycles are counted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Overflow    <= 1'b0;
      DropCount   <= '0;
      StallCount  <= '0;
      BranchCount <= '0;
      JumpCount   <= '0;
    end else begin
      if (drop) Overflow <= 1'b1;
      DropCount   <= sat_inc(DropCount, drop);
      StallCount  <= sat_inc(StallCount, Trace_En & ~ID_PCWrite);
      BranchCount <= sat_inc(BranchCount, Trace_En & ID_BranchTaken);
      JumpCount   <= sat_inc(JumpCount, Trace_En & (ID_DoJump | ID_DoJR));
    end
  end

  // Head record is forced to zero whenever the FIFO is empty.
  assign head_rec = mem[rd_ptr];
  assign Rd_Valid = rd_vld;
  assign Rd_Type  = rd_vld ? head_rec.typ : 1'b0;
  assign Rd_Cycle = rd_vld ? head_rec.cyc : 16'd0;
  assign Rd_PC    = rd_vld ? head_rec.pc  : 32'd0;
  assign Rd_Reg   = rd_vld ? head_rec.rg  : 5'd0;
  assign Rd_Value = rd_vld ? head_rec.val : 32'd0;
  assign Level    = level_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;

  logic        Clk = 1'b0;
  logic        Reset, Trace_En, WB_RegWrite, MEM_MemWrite;
  logic [4:0]  WB_WriteRegister;
  logic [31:0] WB_WriteData, WB_PCPlus8, MEM_PCPlus8;
  logic        ID_PCWrite, ID_BranchTaken, ID_DoJump, ID_DoJR, Rd_Ready;
  logic        Rd_Valid, Rd_Type, Overflow;
  logic [15:0] Rd_Cycle, DropCount, StallCount, BranchCount, JumpCount;
  logic [31:0] Rd_PC, Rd_Value;
  logic [4:0]  Rd_Reg;
  logic [4:0]  Level;

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Trace_En(Trace_En),
    .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister),
    .WB_WriteData(WB_WriteData), .WB_PCPlus8(WB_PCPlus8),
    .MEM_MemWrite(MEM_MemWrite), .MEM_PCPlus8(MEM_PCPlus8),
    .ID_PCWrite(ID_PCWrite), .ID_BranchTaken(ID_BranchTaken),
    .ID_DoJump(ID_DoJump), .ID_DoJR(ID_DoJR), .Rd_Ready(Rd_Ready),
    .Rd_Valid(Rd_Valid), .Rd_Type(Rd_Type), .Rd_Cycle(Rd_Cycle), .Rd_PC(Rd_PC),
    .Rd_Reg(Rd_Reg), .Rd_Value(Rd_Value), .Level(Level), .Overflow(Overflow),
    .DropCount(DropCount), .StallCount(StallCount),
    .BranchCount(BranchCount), .JumpCount(JumpCount)
  );

  always #5 Clk = ~Clk;

  // Reference model: a queue of records plus plain integer counters.
  typedef struct {
    logic        typ;
    int          cyc;
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] val;
  } rec_t;

  rec_t q[$];
  int   m_cycle, m_drop, m_stall, m_branch, m_jump;
  bit   m_ovf;
  int   checks = 0;
  int   errors = 0;

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge to the model using the inputs the DUT sees at that edge.
  task automatic model_edge();
    bit do_pop;
    rec_t r;
    if (Reset) begin
      q.delete();
      m_cycle = 0; m_drop = 0; m_stall = 0; m_branch = 0; m_jump = 0; m_ovf = 0;
      return;
    end
    do_pop = (q.size() > 0) && Rd_Ready;
    if (do_pop) void'(q.pop_front());
    if (Trace_En && (WB_RegWrite || MEM_MemWrite)) begin
      r.cyc = m_cycle;
      r.typ = !WB_RegWrite;
      r.pc  = (WB_RegWrite ? WB_PCPlus8 : MEM_PCPlus8) - 32'd8;
      r.rg  = WB_RegWrite ? WB_WriteRegister : 5'd0;
      r.val = WB_RegWrite ? WB_WriteData : 32'd0;
      if (q.size() < DEPTH) q.push_back(r);
      else begin m_ovf = 1; m_drop = sat(m_drop); end
    end
    if (Trace_En) begin
      if (!ID_PCWrite)            m_stall  = sat(m_stall);
      if (ID_BranchTaken)         m_branch = sat(m_branch);
      if (ID_DoJump || ID_DoJR)   m_jump   = sat(m_jump);
    end
    m_cycle = (m_cycle + 1) % 65536;
  endtask

  task automatic check_all(input string tag);
    bit v;
    v = q.size() > 0;
    chk({tag, ".valid"}, 32'(Rd_Valid), 32'(v));
    chk({tag, ".type"},  32'(Rd_Type),  v ? 32'(q[0].typ) : 32'd0);
    chk({tag, ".cycle"}, 32'(Rd_Cycle), v ? 32'(q[0].cyc) : 32'd0);
    chk({tag, ".pc"},    Rd_PC,         v ? q[0].pc : 32'd0);
    chk({tag, ".reg"},   32'(Rd_Reg),   v ? 32'(q[0].rg) : 32'd0);
    chk({tag, ".value"}, Rd_Value,      v ? q[0].val : 32'd0);
    chk({tag, ".level"}, 32'(Level),    32'(q.size()));
    chk({tag, ".ovf"},   32'(Overflow), 32'(m_ovf));
    chk({tag, ".drop"},  32'(DropCount),   32'(m_drop));
    chk({tag, ".stall"}, 32'(StallCount),  32'(m_stall));
    chk({tag, ".br"},    32'(BranchCount), 32'(m_branch));
    chk({tag, ".jmp"},   32'(JumpCount),   32'(m_jump));
  endtask

  // Inputs are changed at the falling edge; outputs are compared at the next falling edge.
  task automatic tick(input string tag);
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_all(tag);
  endtask

  task automatic idle();
    Reset = 0; Trace_En = 1; WB_RegWrite = 0; MEM_MemWrite = 0;
    WB_WriteRegister = 0; WB_WriteData = 0; WB_PCPlus8 = 0; MEM_PCPlus8 = 0;
    ID_PCWrite = 1; ID_BranchTaken = 0; ID_DoJump = 0; ID_DoJR = 0; Rd_Ready = 0;
  endtask

  task automatic commit(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc8);
    WB_RegWrite = 1; WB_WriteRegister = r; WB_WriteData = d; WB_PCPlus8 = pc8;
  endtask

  task automatic do_reset(input int n);
    Reset = 1;
    for (int i = 0; i < n; i++) tick("reset");
    idle();
  endtask

  initial begin
    idle();
    @(negedge Clk);
    do_reset(2);
    chk("rst_level", 32'(Level), 32'd0);
    chk("rst_valid", 32'(Rd_Valid), 32'd0);

    // Single commit, stamped cycle 0 with PC = PCPlus8 - 8.
    commit(5'd8, 32'hFFFF_FFFB, 32'd12);
    tick("single");
    idle();
    chk("single_cycle", 32'(Rd_Cycle), 32'd0);
    chk("single_pc", Rd_PC, 32'd4);
    chk("single_reg", 32'(Rd_Reg), 32'd8);
    chk("single_val", Rd_Value, 32'hFFFF_FFFB);
    chk("single_lvl", 32'(Level), 32'd1);

    // WB and MEM together yield exactly one type-0 record; a lone store is type 1.
    commit(5'd3, 32'h1234, 32'h100);
    MEM_MemWrite = 1; MEM_PCPlus8 = 32'h200;
    tick("prio");
    chk("prio_lvl", 32'(Level), 32'd2);
    idle();
    MEM_MemWrite = 1; MEM_PCPlus8 = 32'h4;
    tick("store");
    idle();

    // Overflow: 18 commits into a 16-entry FIFO, then drain in order.
    do_reset(1);
    for (int i = 0; i < 18; i++) begin
      commit(5'(i), 32'(i * 3), 32'(100 + 4 * i));
      tick("ovf_fill");
    end
    idle();
    chk("ovf_lvl", 32'(Level), 32'd16);
    chk("ovf_flag", 32'(Overflow), 32'd1);
    chk("ovf_drop", 32'(DropCount), 32'd2);
    Rd_Ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_stamp", 32'(Rd_Cycle), 32'(i));
      tick("ovf_drain");
    end
    chk("ovf_empty", 32'(Level), 32'd0);
    chk("ovf_sticky", 32'(Overflow), 32'd1);
    tick("ovf_ready_empty");
    idle();

    // Full FIFO with simultaneous push and pop keeps Level at DEPTH, no drop.
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      commit(5'd1, 32'(i), 32'h40);
      tick("full_fill");
    end
    commit(5'd2, 32'hDEAD_BEEF, 32'h80);
    Rd_Ready = 1;
    tick("full_pushpop");
    idle();
    chk("full_lvl", 32'(Level), 32'd16);
    chk("full_drop", 32'(DropCount), 32'd0);
    Rd_Ready = 1;
    for (int i = 0; i < 15; i++) tick("full_drain");
    chk("full_tail", Rd_Value, 32'hDEAD_BEEF);
    tick("full_last");
    idle();

    // Empty FIFO with push and ready: push stored, nothing popped.
    commit(5'd9, 32'h77, 32'h10);
    Rd_Ready = 1;
    tick("empty_pushpop");
    chk("empty_pp_lvl", 32'(Level), 32'd1);
    idle();

    // Event counters, then the same events with tracing disabled.
    do_reset(1);
    for (int pass = 0; pass < 2; pass++) begin
      Trace_En = (pass == 0);
      ID_PCWrite = 0;
      for (int i = 0; i < 3; i++) tick("cnt_stall");
      ID_PCWrite = 1; ID_BranchTaken = 1;
      for (int i = 0; i < 2; i++) tick("cnt_branch");
      ID_BranchTaken = 0; ID_DoJump = 1; ID_DoJR = 1;
      tick("cnt_jump");
      idle();
      chk("cnt_stall", 32'(StallCount), 32'd3);
      chk("cnt_branch", 32'(BranchCount), 32'd2);
      chk("cnt_jump", 32'(JumpCount), 32'd1);
    end

    // Trace_En low still lets the consumer drain.
    for (int i = 0; i < 3; i++) begin commit(5'd4, 32'(i), 32'h20); tick("te_fill"); end
    idle(); Trace_En = 0; Rd_Ready = 1;
    tick("te_drain");
    chk("te_drain_lvl", 32'(Level), 32'd2);
    idle();

    // Reset mid-stream with a push and pop requested in the same cycle.
    do_reset(1);
    for (int i = 0; i < 5; i++) begin commit(5'd5, 32'(i), 32'h30); ID_PCWrite = 0; tick("mid_fill"); end
    chk("mid_lvl5", 32'(Level), 32'd5);
    Reset = 1; Rd_Ready = 1;
    tick("mid_reset");
    idle();
    chk("mid_lvl0", 32'(Level), 32'd0);
    chk("mid_valid", 32'(Rd_Valid), 32'd0);
    chk("mid_stall", 32'(StallCount), 32'd0);
    commit(5'd6, 32'h5, 32'h30);
    tick("mid_first");
    idle();
    chk("mid_stamp", 32'(Rd_Cycle), 32'd0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      Reset            = ($urandom_range(0, 199) == 0);
      Trace_En         = ($urandom_range(0, 9) != 0);
      WB_RegWrite      = $urandom_range(0, 1);
      MEM_MemWrite     = $urandom_range(0, 1);
      WB_WriteRegister = 5'($urandom);
      WB_WriteData     = $urandom;
      WB_PCPlus8       = $urandom;
      MEM_PCPlus8      = $urandom;
      ID_PCWrite       = ($urandom_range(0, 3) != 0);
      ID_BranchTaken   = $urandom_range(0, 1);
      ID_DoJump        = $urandom_range(0, 1);
      ID_DoJR          = $urandom_range(0, 1);
      Rd_Ready         = (i % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
